// File: rtl/rf_writeback_arb.sv
// Write-back arbiter in front of the 32x32 register file: merges the in-order ALU
// stream and handshaked long-latency results, tracks outstanding registers, flags starvation.
module rf_writeback_arb #(
    parameter int ADSize       = 5,
    parameter int DASize       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADSize-1:0]    alu_rd,
    input  logic [DASize-1:0]    alu_data,
    input  logic                 ll_valid,
    output logic                 ll_ready,
    input  logic [ADSize-1:0]    ll_rd,
    input  logic [DASize-1:0]    ll_data,
    input  logic                 iss_valid,
    input  logic [ADSize-1:0]    iss_rd,
    output logic [2**ADSize-1:0] busy,
    output logic                 stall_req,
    output logic                 err_waw,
    output logic                 rf_write,
    output logic                 rf_enable,
    output logic [ADSize-1:0]    rf_addr,
    output logic [DASize-1:0]    rf_din
);

    localparam int NREG = 2**ADSize;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [ADSize-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [DASize-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              ready_en_q;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;
    logic              rf_write_q, rf_write_d;
    logic [ADSize-1:0] rf_addr_q, rf_addr_d;
    logic [DASize-1:0] rf_din_q, rf_din_d;

    logic              empty, full, hs, push, pop;
    logic              sel_fifo, sel_byp, sel_ll, sel_any;
    logic [ADSize-1:0] sel_rd;
    logic [DASize-1:0] sel_data;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        // ready_en_q keeps ll_ready low while in reset and for the release cycle
        ll_ready = ready_en_q & ~full;
        hs       = ll_valid & ll_ready;

        sel_fifo = ~alu_valid & ~empty;
        sel_byp  = ~alu_valid & empty & hs;
        sel_ll   = sel_fifo | sel_byp;
        sel_any  = alu_valid | sel_ll;
        push     = hs & ~sel_byp;
        pop      = sel_fifo;

        if (alu_valid) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (sel_fifo) begin
            sel_rd   = fifo_rd_q[rd_ptr_q];
            sel_data = fifo_data_q[rd_ptr_q];
        end else begin
            sel_rd   = ll_rd;
            sel_data = ll_data;
        end

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        // Counter saturates at the limit; stall is sticky until the FIFO drains
        if (empty)
            starve_d = '0;
        else if (alu_valid && (starve_q < STARVE_MAX))
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
        stall_d = empty ? 1'b0 : (stall_q | (starve_d >= STARVE_MAX));

        // Clear first, then set, so a same-cycle issue keeps the register busy
        busy_d = busy_q;
        if (sel_ll && (sel_rd != '0))
            busy_d[sel_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0))
            busy_d[iss_rd] = 1'b1;
        err_d = err_q | (iss_valid & busy_q[iss_rd]);

        rf_write_d = sel_any & (sel_rd != '0);
        rf_addr_d  = rf_write_d ? sel_rd : '0;
        rf_din_d   = rf_write_d ? sel_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            ready_en_q <= 1'b0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_din_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            ready_en_q <= 1'b1;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_din_q   <= rf_din_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ll_rd;
            fifo_data_q[wr_ptr_q] <= ll_data;
        end
    end

    assign busy      = busy_q;
    assign stall_req = stall_q;
    assign err_waw   = err_q;
    assign rf_write  = rf_write_q;
    assign rf_enable = rf_write_q;
    assign rf_addr   = rf_addr_q;
    assign rf_din    = rf_din_q;

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed, table-driven bench for rf_writeback_arb: each row drives one cycle of
// inputs and lists the hand-computed outputs expected just after that edge.
module tb_rf_writeback_arb;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        stall_req;
    logic        err_waw;
    logic        rf_write;
    logic        rf_enable;
    logic [4:0]  rf_addr;
    logic [31:0] rf_din;

    rf_writeback_arb #(
        .ADSize(5), .DASize(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .stall_req(stall_req), .err_waw(err_waw),
        .rf_write(rf_write), .rf_enable(rf_enable), .rf_addr(rf_addr), .rf_din(rf_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic        ewr;
        logic [4:0]  eaddr;
        logic [31:0] edin;
        logic        erdy;
        logic        estall;
        logic        eerr;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic iv, input logic [4:0] ird,
        input logic ewr, input logic [4:0] eaddr, input logic [31:0] edin,
        input logic erdy, input logic estall, input logic eerr, input logic [31:0] ebusy);
        vec_t v;
        v.av = av;   v.ard = ard;     v.adat = adat;
        v.lv = lv;   v.lrd = lrd;     v.ldat = ldat;
        v.iv = iv;   v.ird = ird;
        v.ewr = ewr; v.eaddr = eaddr; v.edin = edin;
        v.erdy = erdy; v.estall = estall; v.eerr = eerr; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        ll_valid  = v.lv; ll_rd  = v.lrd; ll_data  = v.ldat;
        iss_valid = v.iv; iss_rd = v.ird;
        @(posedge clk);
        #1;
        chk({tag, "/rf_write"},  64'(rf_write),  64'(v.ewr));
        chk({tag, "/rf_enable"}, 64'(rf_enable), 64'(v.ewr));
        if (v.ewr) begin
            chk({tag, "/rf_addr"}, 64'(rf_addr), 64'(v.eaddr));
            chk({tag, "/rf_din"},  64'(rf_din),  64'(v.edin));
        end
        chk({tag, "/ll_ready"},  64'(ll_ready),  64'(v.erdy));
        chk({tag, "/stall_req"}, 64'(stall_req), 64'(v.estall));
        chk({tag, "/err_waw"},   64'(err_waw),   64'(v.eerr));
        chk({tag, "/busy"},      64'(busy),      64'(v.ebusy));
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ll_valid  = 0; ll_rd  = 0; ll_data  = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/rf_write"},  64'(rf_write),  64'd0);
        chk({tag, "/rf_enable"}, 64'(rf_enable), 64'd0);
        chk({tag, "/rf_addr"},   64'(rf_addr),   64'd0);
        chk({tag, "/rf_din"},    64'(rf_din),    64'd0);
        chk({tag, "/ll_ready"},  64'(ll_ready),  64'd0);
        chk({tag, "/stall_req"}, 64'(stall_req), 64'd0);
        chk({tag, "/err_waw"},   64'(err_waw),   64'd0);
        chk({tag, "/busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle after reset
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,0,32'h0));
        // ALU write lands one cycle after selection, then clears
        tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,          0,0, 1,5,32'hDEADBEEF, 1,0,0,32'h0));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,0,32'h0));
        // issue r7, wait, bypass result clears busy[7]
        tbl.push_back(mk(0,0,0,            0,0,0,          1,7, 0,0,0,            1,0,0,32'h80));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,0,32'h80));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,0,32'h80));
        tbl.push_back(mk(0,0,0,            1,7,32'h11,     0,0, 1,7,32'h11,       1,0,0,32'h0));
        // rd=0 consumed without a write
        tbl.push_back(mk(0,0,0,            1,0,32'hFF,     0,0, 0,0,0,            1,0,0,32'h0));
        // double issue to r3 -> sticky err_waw
        tbl.push_back(mk(0,0,0,            0,0,0,          1,3, 0,0,0,            1,0,0,32'h8));
        tbl.push_back(mk(0,0,0,            0,0,0,          1,3, 0,0,0,            1,0,1,32'h8));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,1,32'h8));
        // same-cycle issue and commit of r4: set wins
        tbl.push_back(mk(0,0,0,            1,4,32'h44,     1,4, 1,4,32'h44,       1,0,1,32'h18));
        // ALU write to busy r3 leaves busy alone; issue to r0 never sets busy
        tbl.push_back(mk(1,3,32'h33,       0,0,0,          0,0, 1,3,32'h33,       1,0,1,32'h18));
        tbl.push_back(mk(0,0,0,            0,0,0,          1,0, 0,0,0,            1,0,1,32'h18));
        // starvation: ALU every cycle, three ll results offered
        tbl.push_back(mk(1,1,32'hA1,       1,10,32'h100,   0,0, 1,1,32'hA1,       1,0,1,32'h18));
        tbl.push_back(mk(1,1,32'hA2,       1,11,32'h101,   0,0, 1,1,32'hA2,       0,0,1,32'h18));
        tbl.push_back(mk(1,1,32'hA3,       1,12,32'h102,   0,0, 1,1,32'hA3,       0,0,1,32'h18));
        tbl.push_back(mk(1,1,32'hA4,       1,12,32'h102,   0,0, 1,1,32'hA4,       0,0,1,32'h18));
        tbl.push_back(mk(1,1,32'hA5,       1,12,32'h102,   0,0, 1,1,32'hA5,       0,1,1,32'h18));
        tbl.push_back(mk(1,1,32'hA6,       1,12,32'h102,   0,0, 1,1,32'hA6,       0,1,1,32'h18));
        // ALU drops: FIFO drains in order, third result pushed while popping
        tbl.push_back(mk(0,0,0,            1,12,32'h102,   0,0, 1,10,32'h100,     1,1,1,32'h18));
        tbl.push_back(mk(0,0,0,            1,12,32'h102,   0,0, 1,11,32'h101,     1,1,1,32'h18));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 1,12,32'h102,     1,1,1,32'h18));
        tbl.push_back(mk(0,0,0,            0,0,0,          0,0, 0,0,0,            1,0,1,32'h18));

        idle_inputs();
        rst = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release/ll_ready_low", 64'(ll_ready), 64'd0);

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("row%0d", i));

        // reset with two FIFO entries and a write pending
        run_vec(mk(1,2,32'h22, 1,20,32'h200, 0,0, 1,2,32'h22, 1,0,1,32'h18), "t6_fill1");
        run_vec(mk(1,2,32'h23, 1,21,32'h201, 0,0, 1,2,32'h23, 0,0,1,32'h18), "t6_fill2");
        #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_all_zero("t6_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_release/ll_ready_low", 64'(ll_ready), 64'd0);
        run_vec(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,32'h0), "t6_idle1");
        run_vec(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,32'h0), "t6_idle2");
        run_vec(mk(0,0,0, 1,6,32'h66, 0,0, 1,6,32'h66, 1,0,0,32'h0), "t6_bypass");
        run_vec(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,32'h0), "t6_idle3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
